// File: rtl/hazard_sb.sv
// hazard_sb: decode-stage hazard scoreboard for a 5-stage MIPS pipeline.
// It classifies the D-stage instruction and derives the Tuse of each source
// and the Tnew of its destination. Dest/Tnew pairs are tracked in NSTAGE
// post-D slots (1=E, 2=M, 3=W, ...). From these it produces a zero-latency
// stall and the nearest-producer forwarding select for rs and rt.
// Optional feature macro: HAZARD_SB_MDU_EN adds mult/div/mfhi/mflo/mthi/mtlo
// decode and a multiply/divide busy counter.
module hazard_sb #(
    parameter int NSTAGE   = 3,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [2:0]  fwd_rs_d,
    output logic [2:0]  fwd_rt_d,
    output logic [5:0]  cls_d,
    output logic        md_busy
);

    logic [5:0]        op_s;
    logic [5:0]        funct_s;
    logic [4:0]        rs_s;
    logic [4:0]        rt_s;
    logic [4:0]        rd_s;
    logic              use_rs_s;
    logic              use_rt_s;
    logic [TNEW_W-1:0] tuse_rs_s;
    logic [TNEW_W-1:0] tuse_rt_s;
    logic [4:0]        dest_s;
    logic [TNEW_W-1:0] tnew_s;
    logic [2:0]        hit_rs_s;
    logic [2:0]        hit_rt_s;
    logic [TNEW_W-1:0] hit_tnew_rs_s;
    logic [TNEW_W-1:0] hit_tnew_rt_s;
    logic              md_stall_s;
    logic              unused_s;

    logic [4:0]        dest_r [1:NSTAGE];
    logic [TNEW_W-1:0] tnew_r [1:NSTAGE];

    assign op_s     = instr_d[31:26];
    assign rs_s     = instr_d[25:21];
    assign rt_s     = instr_d[20:16];
    assign rd_s     = instr_d[15:11];
    assign funct_s  = instr_d[5:0];
    assign unused_s = ^instr_d[10:6];

`ifdef HAZARD_SB_MDU_EN
    localparam int CNT_W = $clog2(DIV_LAT + 1);
    logic             md_op_s;
    logic             md_start_s;
    logic             md_div_s;
    logic             md_start_r;
    logic             md_div_r;
    logic [CNT_W-1:0] cnt_r;
`endif

    // Decode the D instruction into class, source usage/Tuse and dest/Tnew.
    always_comb begin
        cls_d     = 6'b000000;
        use_rs_s  = 1'b0;
        use_rt_s  = 1'b0;
        tuse_rs_s = TNEW_W'(0);
        tuse_rt_s = TNEW_W'(0);
        dest_s    = 5'd0;
        tnew_s    = TNEW_W'(0);
`ifdef HAZARD_SB_MDU_EN
        md_op_s    = 1'b0;
        md_start_s = 1'b0;
        md_div_s   = 1'b0;
`endif
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h21, 6'h23: begin
                        cls_d = 6'b010000; use_rs_s = 1'b1; use_rt_s = 1'b1;
                        tuse_rs_s = TNEW_W'(1); tuse_rt_s = TNEW_W'(1);
                        dest_s = rd_s; tnew_s = TNEW_W'(1);
                    end
                    6'h08: begin
                        cls_d = 6'b100000; use_rs_s = 1'b1; tuse_rs_s = TNEW_W'(0);
                    end
`ifdef HAZARD_SB_MDU_EN
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        cls_d = 6'b010000; use_rs_s = 1'b1; use_rt_s = 1'b1;
                        tuse_rs_s = TNEW_W'(1); tuse_rt_s = TNEW_W'(1);
                        md_op_s = 1'b1; md_start_s = 1'b1; md_div_s = funct_s[1];
                    end
                    6'h11, 6'h13: begin
                        cls_d = 6'b010000; use_rs_s = 1'b1; tuse_rs_s = TNEW_W'(1);
                        md_op_s = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        cls_d = 6'b010000; dest_s = rd_s; tnew_s = TNEW_W'(1);
                        md_op_s = 1'b1;
                    end
`endif
                    default: cls_d = 6'b000000;
                endcase
            end
            6'h0d, 6'h0f: begin
                cls_d = 6'b001000; use_rs_s = 1'b1; tuse_rs_s = TNEW_W'(1);
                dest_s = rt_s; tnew_s = TNEW_W'(1);
            end
            6'h23: begin
                cls_d = 6'b000100; use_rs_s = 1'b1; tuse_rs_s = TNEW_W'(1);
                dest_s = rt_s; tnew_s = TNEW_W'(2);
            end
            6'h2b: begin
                cls_d = 6'b000010; use_rs_s = 1'b1; use_rt_s = 1'b1;
                tuse_rs_s = TNEW_W'(1); tuse_rt_s = TNEW_W'(2);
            end
            6'h04: begin
                cls_d = 6'b100000; use_rs_s = 1'b1; use_rt_s = 1'b1;
                tuse_rs_s = TNEW_W'(0); tuse_rt_s = TNEW_W'(0);
            end
            6'h03: begin
                cls_d = 6'b000001; dest_s = 5'd31; tnew_s = TNEW_W'(0);
            end
            default: cls_d = 6'b000000;
        endcase
    end

    // Nearest-producer search: scan oldest to youngest so the lowest k wins.
    always_comb begin
        hit_rs_s      = 3'd0;
        hit_rt_s      = 3'd0;
        hit_tnew_rs_s = TNEW_W'(0);
        hit_tnew_rt_s = TNEW_W'(0);
        for (int k = NSTAGE; k >= 1; k--) begin
            if (use_rs_s && (dest_r[k] != 5'd0) && (dest_r[k] == rs_s)) begin
                hit_rs_s      = 3'(k);
                hit_tnew_rs_s = tnew_r[k];
            end else begin
                hit_rs_s      = hit_rs_s;
            end
            if (use_rt_s && (dest_r[k] != 5'd0) && (dest_r[k] == rt_s)) begin
                hit_rt_s      = 3'(k);
                hit_tnew_rt_s = tnew_r[k];
            end else begin
                hit_rt_s      = hit_rt_s;
            end
        end
    end

`ifdef HAZARD_SB_MDU_EN
    assign md_stall_s = md_op_s && ((cnt_r != CNT_W'(0)) || md_start_r);
    assign md_busy    = (cnt_r != CNT_W'(0));
`else
    assign md_stall_s = 1'b0;
    assign md_busy    = 1'b0;
`endif

    // Stall when the nearest producer of a used source is not ready by its Tuse.
    always_comb begin
        stall = md_stall_s
              || ((hit_rs_s != 3'd0) && (hit_tnew_rs_s > tuse_rs_s))
              || ((hit_rt_s != 3'd0) && (hit_tnew_rt_s > tuse_rt_s));
        fwd_rs_d = hit_rs_s;
        fwd_rt_d = hit_rt_s;
    end

    // Slot shift register: load E with the decoded instr (bubble on stall), age the rest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                dest_r[k] <= 5'd0;
                tnew_r[k] <= TNEW_W'(0);
            end
        end else begin
            for (int k = NSTAGE; k >= 2; k--) begin
                dest_r[k] <= dest_r[k-1];
                tnew_r[k] <= (tnew_r[k-1] != TNEW_W'(0)) ? (tnew_r[k-1] - TNEW_W'(1)) : TNEW_W'(0);
            end
            dest_r[1] <= stall ? 5'd0 : dest_s;
            tnew_r[1] <= stall ? TNEW_W'(0) : tnew_s;
        end
    end

`ifdef HAZARD_SB_MDU_EN
    // MDU tracking: tag md-starts in E, then load the latency counter when they leave E.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_start_r <= 1'b0;
            md_div_r   <= 1'b0;
            cnt_r      <= CNT_W'(0);
        end else begin
            md_start_r <= md_start_s && !stall;
            md_div_r   <= md_div_s && !stall;
            if (md_start_r) begin
                cnt_r <= md_div_r ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            end else if (cnt_r != CNT_W'(0)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= CNT_W'(0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb with hand-computed expectations.
module tb_hazard_sb;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr_d;
    logic        stall;
    logic [2:0]  fwd_rs_d;
    logic [2:0]  fwd_rt_d;
    logic [5:0]  cls_d;
    logic        md_busy;

    int vectors;
    int miscompares;
    int nstall;

    hazard_sb dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .instr_d  (instr_d),
        .stall    (stall),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .cls_d    (cls_d),
        .md_busy  (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0005};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        instr_d = 32'h0000_0000;
        for (int i = 0; i < 4; i++) tick();
    endtask

    // Count stall cycles of the instr in D, bounded to 20 cycles.
    task automatic count_stall(output int n);
        n = 0;
        #1;
        while (stall === 1'b1 && n < 20) begin
            n++;
            tick();
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        instr_d     = 32'h0000_0000;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd_rs", 32'(fwd_rs_d), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_cls", 32'(cls_d), 32'd0);
        reset_n = 1'b1;
        tick();

        // T1: lw $1 ; addu $2,$1,$1
        instr_d = itype(6'h23, 5'd0, 5'd1);
        #1 chk("cls_lw", 32'(cls_d), 32'h04);
        tick();
        instr_d = rtype(5'd1, 5'd1, 5'd2, 6'h21);
        #1 chk("t1_stall", 32'(stall), 32'd1);
        chk("cls_addu", 32'(cls_d), 32'h10);
        chk("t1_fwd_e", 32'(fwd_rs_d), 32'd1);
        tick();
        #1 chk("t1_stall_end", 32'(stall), 32'd0);
        chk("t1_fwd_rs", 32'(fwd_rs_d), 32'd2);
        chk("t1_fwd_rt", 32'(fwd_rt_d), 32'd2);
        flush();
        instr_d = rtype(5'd1, 5'd1, 5'd2, 6'h21);
        #1 chk("empty_stall", 32'(stall), 32'd0);
        chk("empty_fwd", 32'(fwd_rs_d), 32'd0);

        // T2: ori $1 ; beq $1,$0
        instr_d = itype(6'h0d, 5'd0, 5'd1);
        #1 chk("cls_ori", 32'(cls_d), 32'h08);
        tick();
        instr_d = itype(6'h04, 5'd1, 5'd0);
        #1 chk("t2_stall", 32'(stall), 32'd1);
        chk("cls_beq", 32'(cls_d), 32'h20);
        tick();
        #1 chk("t2_stall_end", 32'(stall), 32'd0);
        chk("t2_fwd_rs", 32'(fwd_rs_d), 32'd2);
        chk("t2_fwd_rt", 32'(fwd_rt_d), 32'd0);
        flush();

        // T3: ori $0 ; beq $0,$0 -- $0 never matches
        instr_d = itype(6'h0d, 5'd0, 5'd0);
        tick();
        instr_d = itype(6'h04, 5'd0, 5'd0);
        #1 chk("t3_stall", 32'(stall), 32'd0);
        chk("t3_fwd_rs", 32'(fwd_rs_d), 32'd0);
        chk("t3_fwd_rt", 32'(fwd_rt_d), 32'd0);
        flush();

        // T4: jal ; jr $31
        instr_d = {6'h03, 26'h0000100};
        #1 chk("cls_jal", 32'(cls_d), 32'h01);
        tick();
        instr_d = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        #1 chk("t4_stall", 32'(stall), 32'd0);
        chk("t4_fwd_rs", 32'(fwd_rs_d), 32'd1);
        flush();

        // T4b: ori $1 ; ori $1 ; sw $1,5($1) -- nearest producer wins
        instr_d = itype(6'h0d, 5'd0, 5'd1);
        tick();
        tick();
        instr_d = itype(6'h2b, 5'd1, 5'd1);
        #1 chk("cls_sw", 32'(cls_d), 32'h02);
        chk("t4b_stall", 32'(stall), 32'd0);
        chk("t4b_fwd_rs", 32'(fwd_rs_d), 32'd1);
        chk("t4b_fwd_rt", 32'(fwd_rt_d), 32'd1);
        flush();

        // Oldest-slot boundary: producer visible in slot 3, dropped after that.
        instr_d = itype(6'h0d, 5'd0, 5'd1);
        tick();
        instr_d = 32'h0000_0000;
        tick();
        tick();
        instr_d = rtype(5'd1, 5'd1, 5'd2, 6'h21);
        #1 chk("w_fwd_rs", 32'(fwd_rs_d), 32'd3);
        chk("w_stall", 32'(stall), 32'd0);
        tick();
        instr_d = itype(6'h04, 5'd1, 5'd0);
        #1 chk("drop_fwd_rs", 32'(fwd_rs_d), 32'd0);
        chk("drop_stall", 32'(stall), 32'd0);
        flush();

        // T5: mult $1,$2 ; mflo $3  and  div ; mflo
        instr_d = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        tick();
        instr_d = rtype(5'd0, 5'd0, 5'd3, 6'h12);
        count_stall(nstall);
`ifdef HAZARD_SB_MDU_EN
        chk("t5_mult_stall", 32'(nstall), 32'd6);
`else
        chk("t5_mult_stall", 32'(nstall), 32'd0);
`endif
        chk("t5_busy_after", 32'(md_busy), 32'd0);
        flush();
        instr_d = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
        tick();
        instr_d = rtype(5'd0, 5'd0, 5'd3, 6'h12);
        count_stall(nstall);
`ifdef HAZARD_SB_MDU_EN
        chk("t5_div_stall", 32'(nstall), 32'd11);
`else
        chk("t5_div_stall", 32'(nstall), 32'd0);
`endif
        flush();

        // T6: async reset during the T1 stall
        instr_d = itype(6'h23, 5'd0, 5'd1);
        tick();
        instr_d = rtype(5'd1, 5'd1, 5'd2, 6'h21);
        #1 chk("t6_stall_pre", 32'(stall), 32'd1);
        #1 reset_n = 1'b0;
        #1 chk("t6_stall_rst", 32'(stall), 32'd0);
        chk("t6_fwd_rst", 32'(fwd_rs_d), 32'd0);
        #1 reset_n = 1'b1;
        tick();
        #1 chk("t6_stall_post", 32'(stall), 32'd0);
        chk("t6_fwd_post", 32'(fwd_rs_d), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
